spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_pkg.sv | 18 +
 rtl/rr_pick.sv | 31 +++
 rtl/spi_arbiter.sv | 146 ++++++++++++++
 tb/tb_spi_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI arbiter: FSM state encoding and chip-select counter type.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package spi_pkg;

  // Width of the CS_SETUP / CS_HOLD cycle counters (supports 1..15).
  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SEND  = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority search: one-hot winner among req, searching from index ptr+1, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to latch the winner.
// Ports: req (request vector), ptr (index of the last winner), winner (one-hot, all zero if no req).
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] winner
);

  logic found;
  int   idx;

  // The last winner is visited last (k = N_REQ), so it only wins when alone.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI byte shifter between N_REQ requesters, with per-slave ss_n.
// Latency: grant+ss_n one cycle after req in IDLE; tx_start CS_SETUP cycles after grant; next byte 1 cycle after tx_done.
// Backpressure: each requester holds req/data/last until ack; ack pulses the cycle after tx_done.
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   req/data/last      per-requester burst request, offered byte (8 bits per lane), final-byte flag
//   grant/ack/ss_n     one-hot owner, byte-consumed pulse, active-low chip selects (= ~grant)
//   tx_start/tx_data   byte shifter launch pulse and byte; tx_done is the shifter's completion pulse
//   busy               high whenever the FSM is outside IDLE
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] data,
  input  logic [N_REQ-1:0]   last,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   ss_n,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_done,
  output logic               busy
);

  localparam int PTR_W = $clog2(N_REQ);

  state_t           state;
  cnt_t             cnt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gidx;
  logic [N_REQ-1:0] winner;
  logic [7:0]       sel_byte;
  logic             req_g;
  logic             last_g;
  logic             last_q;
  logic             drop_q;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner)
  );

  // Decode the granted lane: its index, its offered byte, its req and last bits.
  always_comb begin
    gidx     = '0;
    sel_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gidx     = PTR_W'(i);
        sel_byte = data[8*i +: 8];
      end
    end
  end

  assign req_g  = |(req & grant);
  assign last_g = |(last & grant);

  // ack and the following tx_start share a cycle, so the byte is taken live from the
  // granted lane during the tx_start cycle; the requester advances its byte on ack.
  assign tx_data = tx_start ? sel_byte : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      grant    <= '0;
      ss_n     <= '1;
      ack      <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      last_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      ack      <= '0;
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= winner;
            ss_n  <= ~winner;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == cnt_t'(CS_SETUP - 1)) begin
            cnt      <= '0;
            tx_start <= 1'b1;
            state    <= SEND;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SEND: begin
          last_q <= last_g;
          drop_q <= ~req_g;
          state  <= WAIT;
        end
        WAIT: begin
          // A req drop anywhere in WAIT is sticky so a re-raise cannot extend the burst.
          if (!req_g) begin
            drop_q <= 1'b1;
          end
          if (tx_done) begin
            ack <= grant;
            if (!last_q && !drop_q && req_g) begin
              tx_start <= 1'b1;
              state    <= SEND;
            end else begin
              cnt   <= '0;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (cnt == cnt_t'(CS_HOLD - 1)) begin
            cnt   <= '0;
            grant <= '0;
            ss_n  <= '1;
            busy  <= 1'b0;
            ptr   <= gidx;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
module tb_spi_arbiter;

  localparam int N     = 4;
  localparam int SETUP = 2;
  localparam int HOLD  = 2;
  localparam int LAT   = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] data = '0;
  logic [N-1:0]   last = '0;
  logic [N-1:0]   grant, ack, ss_n;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_done;
  logic           busy;
  logic           shf_done = 1'b0;
  logic           stray_done = 1'b0;

  assign tx_done = shf_done | stray_done;

  always #5 clk = ~clk;

  spi_arbiter #(.N_REQ(N), .CS_SETUP(SETUP), .CS_HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .last(last),
    .grant(grant), .ack(ack), .ss_n(ss_n),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done), .busy(busy)
  );

  typedef struct {int c; int idx; logic [7:0] b; logic [3:0] s;} ev_t;
  ev_t        start_q[$], ack_q[$], gnt_q[$];
  int         done_q[$], rise_q[$];
  logic [8:0] bq[N][$];
  logic [N-1:0] kill = '0;
  int checks = 0, errors = 0, cyc = 0, viol = 0, sh_cnt = 0, mptr = 0;
  bit mon_en = 0;
  logic [N-1:0] prev_grant = '0, prev_ssn = '1;
  logic prev_start = 1'b0;

  function automatic int oh2i(logic [3:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference arbitration rule: first requester after the previous winner, wrapping.
  function automatic int rr_model(logic [3:0] r, int p);
    for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge clk) cyc++;

  // Requesters: each lane offers the head of its queue and pops it on ack.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++)
      if (!rst && ack[i] && bq[i].size() > 0) void'(bq[i].pop_front());
    for (int i = 0; i < N; i++) begin
      req[i]         = (bq[i].size() > 0) && !kill[i];
      data[8*i +: 8] = (bq[i].size() > 0) ? bq[i][0][7:0] : 8'h00;
      last[i]        = (bq[i].size() > 0) ? bq[i][0][8] : 1'b0;
    end
  end

  // Shifter model (tx_done LAT cycles after tx_start) plus event log and invariants.
  always @(negedge clk) begin
    if (rst) begin
      sh_cnt = 0; shf_done = 1'b0;
    end else begin
      shf_done = 1'b0;
      if (sh_cnt > 0) begin
        sh_cnt--;
        if (sh_cnt == 0) begin shf_done = 1'b1; done_q.push_back(cyc); end
      end
      if (tx_start) sh_cnt = LAT;
    end
    if (mon_en) begin
      if ($countones(grant) > 1 || $countones(ack) > 1 || $countones(~ss_n) > 1) viol++;
      if (ss_n !== ~grant || (!busy && grant !== '0) || (ack & ~grant) !== '0) viol++;
      if (tx_start && prev_start) viol++;
      if (tx_start) start_q.push_back('{cyc, oh2i(grant), tx_data, ss_n});
      if (ack !== '0) ack_q.push_back('{cyc, oh2i(ack), 8'h00, ss_n});
      if (grant !== '0 && prev_grant === '0) gnt_q.push_back('{cyc, oh2i(grant), 8'h00, ss_n});
      if (ss_n === '1 && prev_ssn !== '1) rise_q.push_back(cyc);
    end
    prev_grant = grant; prev_ssn = ss_n; prev_start = tx_start;
  end

  task automatic clear_logs;
    start_q.delete(); ack_q.delete(); gnt_q.delete(); done_q.delete(); rise_q.delete();
  endtask

  task automatic wait_quiet(input int budget, output bit to);
    to = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy && req == '0) begin to = 1'b0; break; end
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b want 0000", ack); end
    checks++; if (ss_n !== 4'b1111) begin errors++; $display("FAIL reset_ss_n got %b want 1111", ss_n); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0; mptr = 0; mon_en = 1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || grant !== '0) begin errors++; $display("FAIL reset_idle busy=%b grant=%b want 0/0000", busy, grant); end
  endtask

  task automatic test_single_byte;
    bit to; int w;
    clear_logs();
    w = rr_model(4'b0010, mptr);
    bq[1].push_back({1'b1, 8'hA5});
    wait_quiet(500, to);
    checks++; if (to) begin errors++; $display("FAIL single_timeout busy=%b req=%b", busy, req); end
    checks++; if (gnt_q.size() != 1 || gnt_q[0].idx != w || gnt_q[0].s !== 4'b1101)
      begin errors++; $display("FAIL single_grant n=%0d idx=%0d ss_n=%b want 1/%0d/1101", gnt_q.size(), gnt_q[0].idx, gnt_q[0].s, w); end
    checks++; if (start_q.size() != 1 || start_q[0].b !== 8'hA5 || start_q[0].c != gnt_q[0].c + SETUP)
      begin errors++; $display("FAIL single_start n=%0d byte=%h cyc=%0d want 1/a5/%0d", start_q.size(), start_q[0].b, start_q[0].c, gnt_q[0].c + SETUP); end
    checks++; if (ack_q.size() != 1 || ack_q[0].idx != 1 || ack_q[0].c != done_q[0] + 1)
      begin errors++; $display("FAIL single_ack n=%0d idx=%0d cyc=%0d want 1/1/%0d", ack_q.size(), ack_q[0].idx, ack_q[0].c, done_q[0] + 1); end
    checks++; if (rise_q.size() != 1 || rise_q[0] != done_q[0] + HOLD + 1)
      begin errors++; $display("FAIL single_ss_rise n=%0d cyc=%0d want 1/%0d", rise_q.size(), rise_q[0], done_q[0] + HOLD + 1); end
    mptr = w;
  endtask

  task automatic test_burst;
    bit to; logic [7:0] exp_b[3];
    exp_b = '{8'h11, 8'h22, 8'h33};
    clear_logs();
    for (int k = 0; k < 3; k++) bq[0].push_back({k == 2, exp_b[k]});
    wait_quiet(1000, to);
    checks++; if (to) begin errors++; $display("FAIL burst_timeout busy=%b req=%b", busy, req); end
    checks++; if (start_q.size() != 3) begin errors++; $display("FAIL burst_starts got %0d want 3", start_q.size()); end
    else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (start_q[k].b !== exp_b[k] || start_q[k].idx != 0)
          begin errors++; $display("FAIL burst_byte%0d got %h/lane%0d want %h/lane0", k, start_q[k].b, start_q[k].idx, exp_b[k]); end
      end
      for (int k = 1; k < 3; k++) begin
        checks++; if (start_q[k].c != done_q[k-1] + 1)
          begin errors++; $display("FAIL burst_gap%0d start=%0d want %0d", k, start_q[k].c, done_q[k-1] + 1); end
      end
    end
    checks++; if (ack_q.size() != 3) begin errors++; $display("FAIL burst_acks got %0d want 3", ack_q.size()); end
    checks++; if (gnt_q.size() != 1 || rise_q.size() != 1)
      begin errors++; $display("FAIL burst_ss_low grants=%0d rises=%0d want 1/1", gnt_q.size(), rise_q.size()); end
    mptr = 0;
  endtask

  task automatic test_early_drop;
    bit to; logic [7:0] b[4];
    clear_logs();
    for (int k = 0; k < 4; k++) begin b[k] = 8'($urandom); bq[2].push_back({k == 3, b[k]}); end
    for (int k = 0; k < 300 && start_q.size() < 2; k++) begin @(negedge clk); #1; end
    repeat (5) @(negedge clk);
    kill[2] = 1'b1;
    wait_quiet(500, to);
    checks++; if (to) begin errors++; $display("FAIL drop_timeout busy=%b req=%b", busy, req); end
    checks++; if (start_q.size() != 2 || start_q[0].b !== b[0] || start_q[1].b !== b[1])
      begin errors++; $display("FAIL drop_starts n=%0d b0=%h b1=%h want 2/%h/%h", start_q.size(), start_q[0].b, start_q[1].b, b[0], b[1]); end
    checks++; if (ack_q.size() != 2) begin errors++; $display("FAIL drop_acks got %0d want 2", ack_q.size()); end
    checks++; if (rise_q.size() != 1 || rise_q[0] != done_q[1] + HOLD + 1 || busy !== 1'b0)
      begin errors++; $display("FAIL drop_hold rise=%0d busy=%b want %0d/0", rise_q[0], busy, done_q[1] + HOLD + 1); end
    bq[2].delete(); kill = '0; mptr = 2;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stray_done;
    bit to; int w; logic [7:0] b;
    clear_logs();
    @(negedge clk); stray_done = 1'b1;
    @(negedge clk); stray_done = 1'b0;
    repeat (2) @(negedge clk); #1;
    checks++; if (ack_q.size() != 0 || busy !== 1'b0 || gnt_q.size() != 0)
      begin errors++; $display("FAIL stray_idle acks=%0d busy=%b grants=%0d want 0/0/0", ack_q.size(), busy, gnt_q.size()); end
    b = 8'($urandom);
    w = rr_model(4'b1000, mptr);
    bq[3].push_back({1'b1, b});
    for (int k = 0; k < 20 && gnt_q.size() == 0; k++) begin @(negedge clk); #1; end
    stray_done = 1'b1;
    @(negedge clk); #1; stray_done = 1'b0;
    wait_quiet(500, to);
    checks++; if (to) begin errors++; $display("FAIL stray_timeout busy=%b", busy); end
    checks++; if (gnt_q.size() != 1 || gnt_q[0].idx != w)
      begin errors++; $display("FAIL stray_grant n=%0d idx=%0d want 1/%0d", gnt_q.size(), gnt_q[0].idx, w); end
    checks++; if (start_q.size() != 1 || start_q[0].c != gnt_q[0].c + SETUP || start_q[0].b !== b)
      begin errors++; $display("FAIL stray_setup n=%0d cyc=%0d byte=%h want 1/%0d/%h", start_q.size(), start_q[0].c, start_q[0].b, gnt_q[0].c + SETUP, b); end
    checks++; if (ack_q.size() != 1 || ack_q[0].c != done_q[0] + 1)
      begin errors++; $display("FAIL stray_ack n=%0d cyc=%0d want 1/%0d", ack_q.size(), ack_q[0].c, done_q[0] + 1); end
    mptr = w;
  endtask

  task automatic test_contention;
    bit to; int ord[$]; int cnt[N]; int p; int w; logic [3:0] r; logic [7:0] eb[N][$]; logic [7:0] x;
    clear_logs();
    for (int i = 0; i < N; i++) begin
      cnt[i] = (i == 0) ? 2 : 1;
      for (int j = 0; j < cnt[i]; j++) begin x = 8'($urandom); eb[i].push_back(x); bq[i].push_back({1'b1, x}); end
    end
    p = mptr;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++) r[i] = cnt[i] > 0;
      w = rr_model(r, p); ord.push_back(w); cnt[w]--; p = w;
    end
    wait_quiet(3000, to);
    checks++; if (to) begin errors++; $display("FAIL cont_timeout busy=%b req=%b", busy, req); end
    checks++; if (gnt_q.size() != 5 || start_q.size() != 5)
      begin errors++; $display("FAIL cont_count grants=%0d starts=%0d want 5/5", gnt_q.size(), start_q.size()); end
    else begin
      for (int k = 0; k < 5; k++) begin
        x = eb[ord[k]].pop_front();
        checks++; if (gnt_q[k].idx != ord[k] || start_q[k].b !== x)
          begin errors++; $display("FAIL cont_order%0d lane=%0d byte=%h want %0d/%h", k, gnt_q[k].idx, start_q[k].b, ord[k], x); end
        if (k > 0) begin
          checks++; if (gnt_q[k].c != rise_q[k-1] + 1)
            begin errors++; $display("FAIL cont_idle%0d grant=%0d want %0d", k, gnt_q[k].c, rise_q[k-1] + 1); end
        end
      end
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL cont_onehot violations=%0d want 0", viol); end
    mptr = ord[4];
  endtask

  task automatic test_reset_mid_burst;
    bit to; int w0, w1;
    clear_logs();
    for (int k = 0; k < 3; k++) bq[1].push_back({k == 2, 8'($urandom)});
    for (int k = 0; k < 300 && start_q.size() == 0; k++) begin @(negedge clk); #1; end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ss_n !== 4'hF || busy !== 1'b0 || grant !== 4'h0 || tx_start !== 1'b0)
      begin errors++; $display("FAIL midrst_state ss_n=%h busy=%b grant=%h tx_start=%b want f/0/0/0", ss_n, busy, grant, tx_start); end
    for (int i = 0; i < N; i++) bq[i].delete();
    @(negedge clk);
    rst = 1'b0; mptr = 0;
    repeat (2) @(negedge clk);
    clear_logs();
    w0 = rr_model(4'b1001, mptr);
    w1 = rr_model(4'b1001 & ~(4'b0001 << w0), w0);
    bq[0].push_back({1'b1, 8'($urandom)});
    bq[3].push_back({1'b1, 8'($urandom)});
    wait_quiet(1000, to);
    checks++; if (to) begin errors++; $display("FAIL midrst_timeout busy=%b", busy); end
    checks++; if (gnt_q.size() != 2 || gnt_q[0].idx != w0 || gnt_q[1].idx != w1)
      begin errors++; $display("FAIL midrst_order n=%0d first=%0d second=%0d want 2/%0d/%0d", gnt_q.size(), gnt_q[0].idx, gnt_q[1].idx, w0, w1); end
    checks++; if (ack_q.size() != 2 || ack_q[0].idx != w0 || done_q.size() != 2)
      begin errors++; $display("FAIL midrst_acks n=%0d first=%0d dones=%0d want 2/%0d/2", ack_q.size(), ack_q[0].idx, done_q.size(), w0); end
    checks++; if (viol != 0) begin errors++; $display("FAIL final_invariants violations=%0d want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_early_drop();
    test_stray_done();
    test_contention();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
